// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states and error codes.
package lsu_pkg;

  localparam int LP_XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store steering, access checking and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]         i_funct3,
  input  logic               i_is_store,
  input  logic [1:0]         i_addr_lo,
  input  logic [LP_XLEN-1:0] i_wdata,
  output logic [3:0]         o_be,
  output logic [LP_XLEN-1:0] o_wdata,
  output logic [1:0]         o_err,
  input  logic [2:0]         i_ld_funct3,
  input  logic [1:0]         i_ld_addr_lo,
  input  logic [LP_XLEN-1:0] i_mem_rdata,
  output logic [LP_XLEN-1:0] o_ld_data
);

  logic       w_valid;
  logic       w_misaligned;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  // funct3[1:0] gives the access size for both signed and unsigned variants
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = '0;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      2'b10: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = '0;
      end
    endcase
    if (!i_is_store) begin
      o_wdata = '0;
    end
  end

  always_comb begin
    if (i_is_store) begin
      w_valid = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
    end else begin
      w_valid = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
    end
    w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
    if (!w_valid) begin
      o_err = ERR_FUNCT3;
    end else if (w_misaligned) begin
      o_err = ERR_MISALIGN;
    end else begin
      o_err = ERR_OK;
    end
  end

  always_comb begin
    case (i_ld_addr_lo)
      2'b00:   w_byte = i_mem_rdata[7:0];
      2'b01:   w_byte = i_mem_rdata[15:8];
      2'b10:   w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    // funct3[2] set means zero-extend
    case (i_ld_funct3[1:0])
      2'b00:   o_ld_data = {{24{w_byte[7] & ~i_ld_funct3[2]}}, w_byte};
      2'b01:   o_ld_data = {{16{w_half[15] & ~i_ld_funct3[2]}}, w_half};
      default: o_ld_data = i_mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: FSM, request registers and timeout counter around lsu_align.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_is_store,
  input  logic [2:0]                   i_funct3,
  input  logic [WIDTH_DATA_LENGTH-1:0] i_addr,
  input  logic [WIDTH_DATA_LENGTH-1:0] i_wdata,
  output logic                         o_stall,
  output logic                         o_done,
  output logic [WIDTH_DATA_LENGTH-1:0] o_rdata,
  output logic [1:0]                   o_err,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [WIDTH_DATA_LENGTH-1:0] o_mem_addr,
  output logic [3:0]                   o_mem_be,
  output logic [WIDTH_DATA_LENGTH-1:0] o_mem_wdata,
  input  logic                         i_mem_ready,
  input  logic [WIDTH_DATA_LENGTH-1:0] i_mem_rdata
);

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e                   r_state;
  logic                         r_is_store;
  logic [2:0]                   r_funct3;
  logic [1:0]                   r_addr_lo;
  logic [7:0]                   r_cnt;
  logic                         r_done;
  logic [1:0]                   r_err;
  logic [WIDTH_DATA_LENGTH-1:0] r_rdata;
  logic                         r_mem_req;
  logic                         r_mem_we;
  logic [WIDTH_DATA_LENGTH-1:0] r_mem_addr;
  logic [3:0]                   r_mem_be;
  logic [WIDTH_DATA_LENGTH-1:0] r_mem_wdata;

  logic [3:0]                   w_be;
  logic [WIDTH_DATA_LENGTH-1:0] w_wdata;
  logic [1:0]                   w_err;
  logic [WIDTH_DATA_LENGTH-1:0] w_ld_data;

  lsu_align u_align (
    .i_funct3     (i_funct3),
    .i_is_store   (i_is_store),
    .i_addr_lo    (i_addr[1:0]),
    .i_wdata      (i_wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_err        (w_err),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_mem_rdata  (i_mem_rdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_cnt       <= 8'd0;
      r_done      <= 1'b0;
      r_err       <= ERR_OK;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_is_store <= i_is_store;
            r_funct3   <= i_funct3;
            r_addr_lo  <= i_addr[1:0];
            r_cnt      <= 8'd0;
            if (w_err != ERR_OK) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_err   <= w_err;
            end else begin
              r_state     <= ST_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= i_is_store;
              r_mem_addr  <= {i_addr[WIDTH_DATA_LENGTH-1:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (i_mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_err     <= ERR_OK;
            if (!r_is_store) begin
              r_rdata <= w_ld_data;
            end
          end else if (r_cnt == LP_CNT_LAST) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_err     <= ERR_TIMEOUT;
            r_rdata   <= '0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_cnt   <= 8'd0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall is combinational in IDLE so the core freezes in the same cycle it issues start
  assign o_stall = i_rst_n & ((r_state == ST_IDLE) ? i_start : (r_state == ST_REQ));

  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a scoreboard queue and a simple memory responder.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.WIDTH_DATA_LENGTH(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_is_store  (is_store),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_stall     (stall),
    .o_done      (done),
    .o_rdata     (rdata),
    .o_err       (err),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_be    (mem_be),
    .o_mem_wdata (mem_wdata),
    .i_mem_ready (mem_ready),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          waits;
    logic [1:0]  err;
    logic        chk_rd;
    logic [31:0] rd;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwd;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   c0;
  } sb_t;

  sb_t  sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   req_cnt = 0;
  bit   saw_req = 1'b0;
  vec_t vecs[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                              input int waits, input logic [1:0] e, input logic chk_rd,
                              input logic [31:0] rd, input logic we, input logic [31:0] maddr,
                              input logic [3:0] be, input logic [31:0] mwd, input int lat);
    vec_t v;
    v.name = name; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrd = mrd;
    v.waits = waits; v.err = e; v.chk_rd = chk_rd; v.rd = rd; v.we = we;
    v.maddr = maddr; v.be = be; v.mwd = mwd; v.lat = lat;
    return v;
  endfunction

  // Memory model: answers after 'waits' REQ cycles and checks the request on its first cycle
  always @(negedge clk) begin
    if (mem_req && sb_q.size() > 0) begin
      saw_req = 1'b1;
      if (req_cnt == 0) begin
        chk({sb_q[0].v.name, "_we"},    {31'h0, mem_we}, {31'h0, sb_q[0].v.we});
        chk({sb_q[0].v.name, "_maddr"}, mem_addr,        sb_q[0].v.maddr);
        chk({sb_q[0].v.name, "_be"},    {28'h0, mem_be}, {28'h0, sb_q[0].v.be});
        chk({sb_q[0].v.name, "_mwdata"}, mem_wdata,      sb_q[0].v.mwd);
      end else begin
        chk({sb_q[0].v.name, "_addr_stable"}, mem_addr, sb_q[0].v.maddr);
      end
      chk({sb_q[0].v.name, "_stall_req"}, {31'h0, stall}, 32'h1);
      mem_ready = (req_cnt == sb_q[0].v.waits);
      mem_rdata = mem_ready ? sb_q[0].v.mrd : 32'h0BAD_0BAD;
      req_cnt++;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      req_cnt   = 0;
    end
  end

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual=done required=no_done");
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        $display("txn %s err=%0d rdata=%h latency=%0d", e.v.name, err, rdata, cyc - e.c0);
        chk({e.v.name, "_err"}, {30'h0, err}, {30'h0, e.v.err});
        if (e.v.chk_rd) chk({e.v.name, "_rdata"}, rdata, e.v.rd);
        chk({e.v.name, "_latency"}, cyc - e.c0, e.v.lat);
        chk({e.v.name, "_stall_done"}, {31'h0, stall}, 32'h0);
        chk({e.v.name, "_req_done"}, {31'h0, mem_req}, 32'h0);
        if (e.v.err == 2'b01 || e.v.err == 2'b11)
          chk({e.v.name, "_no_req"}, {31'h0, saw_req}, 32'h0);
      end
    end
  end

  task automatic issue(input vec_t v);
    sb_t e;
    @(negedge clk);
    is_store = v.st; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    saw_req = 1'b0;
    start = 1'b1;
    e.v = v; e.c0 = cyc;
    sb_q.push_back(e);
    #1 chk({v.name, "_stall_idle"}, {31'h0, stall}, 32'h1);
  endtask

  task automatic run_vec(input vec_t v);
    bit got;
    issue(v);
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_wait actual=no_done required=done", v.name);
    end
    @(negedge clk);
    chk({v.name, "_done_pulse"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    //      name         st f3      addr          wdata         mrd           w     err    crd rd            we maddr         be       mwd           lat
    vecs.push_back(mk("lw_100",   0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0,    2'b00, 1, 32'hDEAD_BEEF, 0, 32'h0000_0100, 4'b1111, 32'h0,        2));
    vecs.push_back(mk("lb_103",   0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0,    2'b00, 1, 32'hFFFF_FF80, 0, 32'h0000_0100, 4'b1000, 32'h0,        2));
    vecs.push_back(mk("lbu_103",  0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0,    2'b00, 1, 32'h0000_0080, 0, 32'h0000_0100, 4'b1000, 32'h0,        2));
    vecs.push_back(mk("sh_202",   1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        2,    2'b00, 1, 32'h0000_0080, 1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 4));
    vecs.push_back(mk("lw_101",   0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         0,    2'b01, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        1));
    vecs.push_back(mk("sh_201",   1, 3'b001, 32'h0000_0201, 32'h1234_ABCD, 32'h0,        0,    2'b01, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        1));
    vecs.push_back(mk("sb_3_to",  1, 3'b000, 32'h0000_0003, 32'h0000_0055, 32'h0,        1000, 2'b10, 1, 32'h0,         1, 32'h0000_0000, 4'b1000, 32'h5555_5555, 17));
    vecs.push_back(mk("lh_102",   0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 0,    2'b00, 1, 32'hFFFF_8001, 0, 32'h0000_0100, 4'b1100, 32'h0,        2));
    vecs.push_back(mk("lhu_100",  0, 3'b101, 32'h0000_0100, 32'h0,        32'h8001_F234, 0,    2'b00, 1, 32'h0000_F234, 0, 32'h0000_0100, 4'b0011, 32'h0,        2));
    vecs.push_back(mk("lb_101_w1",0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 1,    2'b00, 1, 32'h0000_007F, 0, 32'h0000_0100, 4'b0010, 32'h0,        3));
    vecs.push_back(mk("sw_10",    1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,        0,    2'b00, 1, 32'h0000_007F, 1, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 2));
    vecs.push_back(mk("sb_1",     1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'h0,        0,    2'b00, 1, 32'h0000_007F, 1, 32'h0000_0000, 4'b0010, 32'hABAB_ABAB, 2));
    vecs.push_back(mk("ld_f3_011",0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0,    2'b11, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        1));
    vecs.push_back(mk("ld_f3_111",0, 3'b111, 32'h0000_0003, 32'h0,        32'h0,         0,    2'b11, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        1));
    vecs.push_back(mk("st_f3_100",1, 3'b100, 32'h0000_0001, 32'h0,        32'h0,         0,    2'b11, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        1));
    vecs.push_back(mk("st_f3_101",1, 3'b101, 32'h0000_0002, 32'h0,        32'h0,         0,    2'b11, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        1));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stall",  {31'h0, stall},   32'h0);
    chk("rst_done",   {31'h0, done},    32'h0);
    chk("rst_req",    {31'h0, mem_req}, 32'h0);
    chk("rst_rdata",  rdata,            32'h0);
    chk("rst_err",    {30'h0, err},     32'h0);
    chk("rst_maddr",  mem_addr,         32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a stalled request
    issue(mk("lw_40_rst", 0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 1000, 2'b00, 0, 32'h0,
             0, 32'h0000_0040, 4'b1111, 32'h0, 0));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_req_before_rst", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    $display("txn async_reset mem_req=%0d stall=%0d mem_addr=%h", mem_req, stall, mem_addr);
    chk("arst_req",    {31'h0, mem_req}, 32'h0);
    chk("arst_stall",  {31'h0, stall},   32'h0);
    chk("arst_maddr",  mem_addr,         32'h0);
    chk("arst_be",     {28'h0, mem_be},  32'h0);
    chk("arst_rdata",  rdata,            32'h0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the 32-bit ALU in the RISC-V core.
- Takes the ALU result as the effective address, steers store data into byte lanes with byte enables, and runs a req/ready handshake to data memory.
- Aligns and sign- or zero-extends load data, and stalls the core while an access is outstanding.
- Reports misaligned accesses, invalid funct3 codes and memory timeouts.

Parameters:
- WIDTH_DATA_LENGTH, 32: data and address width. Only 32 is supported.
- TIMEOUT_CYCLES, 16: maximum number of cycles in REQ without mem_ready before a bus error is flagged. Range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  core requests a load or store. Sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RISC-V width/sign code: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
- addr  input  32  effective address, taken from ALU_Out.
- wdata  input  32  store data (rs2).
- stall  output  1  holds the core PC and pipeline registers.
- done  output  1  one-cycle pulse; the access is complete.
- rdata  output  32  load result; valid while done=1.
- err  output  2  valid while done=1: 00 ok, 01 misaligned, 10 bus timeout, 11 invalid funct3.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  32  word address, {addr[31:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-replicated store data.
- mem_ready  input  1  memory accepted the request; for loads, mem_rdata is valid in the same cycle.
- mem_rdata  input  32  memory read word.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - State goes to IDLE.
  - All outputs go to 0: stall, done, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
  - Timeout counter goes to 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - stall = start, combinational.
  - On start=1, the block registers is_store, funct3, addr[1:0] and the lane-steered data.
  - If funct3 is invalid, or the access is misaligned, the next state is DONE with the matching err, and no memory request is issued.
  - Otherwise the next state is REQ.
- REQ:
  - mem_req=1 and stall=1.
  - mem_addr, mem_we, mem_be and mem_wdata come from registers and stay stable until mem_ready is seen.
  - The counter increments each cycle.
  - mem_ready=1: capture mem_rdata, go to DONE with err=00.
  - Counter reaches TIMEOUT_CYCLES with no mem_ready: drop mem_req, go to DONE with err=10 and rdata=0.
- DONE:
  - done=1 and stall=0, so the core advances on this edge.
  - start is ignored in DONE. The next access is accepted in the following IDLE cycle, so there is at least 1 bubble between accesses.
  - Next state is IDLE. The counter clears.
- Latency:
  - Error cases: done 1 cycle after start.
  - Normal case with mem_ready in the first REQ cycle: done 2 cycles after start.
  - Each wait cycle adds 1.
- Invalid funct3:
  - Loads: 011, 110, 111.
  - Stores: anything other than 000, 001, 010.
  - Invalid funct3 takes priority over misalignment.
- Misaligned:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=00.
- Store lane steering:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011 when addr[1]=0, 1100 when addr[1]=1; wdata = halfword replicated x2.
  - SW: be = 1111.
- Load extraction:
  - Byte lane is selected by addr[1:0]; halfword lane by addr[1].
  - LB and LH sign-extend to 32 bits; LBU and LHU zero-extend.
- On a load, mem_be reflects the access size. On a load, mem_wdata = 0.
- rdata holds its last value outside DONE. Stores leave rdata unchanged.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - the err codes (ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_FUNCT3).
- One combinational sub-module, lsu_align, covers:
  - store steering: be and wdata from funct3, addr[1:0] and wdata;
  - load extraction and extension from funct3, addr[1:0] and mem_rdata;
  - funct3 and alignment checking.
- load_store_unit holds the FSM, registers and timeout counter.

Test Plan:
- LW at addr=0x100, mem_ready=1 in the first REQ cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, done 2 cycles after start, rdata=0xDEADBEEF, err=00.
- LB at 0x103 and LBU at 0x103, mem_rdata=0x80FF0000 -> LB rdata=0xFFFFFF80; LBU rdata=0x00000080.
- SH at 0x202, wdata=0x1234ABCD -> mem_we=1, mem_addr=0x200, be=1100, mem_wdata=0xABCDABCD; done=1 with err=00 after mem_ready.
- LW at 0x101 and SH at 0x201 -> done 1 cycle after start, err=01, mem_req never asserted.
- SB at 0x3, wdata=0x55 -> be=1000, mem_wdata=0x55555555; with mem_ready held 0 for TIMEOUT_CYCLES=16 cycles -> err=10, mem_req drops, stall=0 during the done cycle.
- rst_n pulsed low mid-REQ with mem_ready low -> mem_req and stall go to 0 asynchronously; after release, a fresh LW completes normally.
